// File: rtl/core_pkg.sv
// Shared types for the issue-stage register scoreboard: the tracker entry
// layout and the standard result-latency codes.
package core_pkg;

  // Field widths are sized for the largest supported configuration
  // (up to 256 registers, up to 15 stages). Narrower ports are zero-extended.
  localparam int SB_REG_W = 8;
  localparam int SB_LAT_W = 4;

  localparam logic [SB_LAT_W-1:0] LAT_ALU  = SB_LAT_W'(1);
  localparam logic [SB_LAT_W-1:0] LAT_LOAD = SB_LAT_W'(2);

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [SB_REG_W-1:0] rd;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;

  // A tracked write satisfies a read of rs; x0 never matches.
  function automatic logic entry_hits(input sb_entry_t e, input logic [SB_REG_W-1:0] rs);
    return e.valid && e.we && (e.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Per-operand youngest-match search over the tracker, producing the stall
// request and the bypass stage for one source register.
module sb_match
  import core_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int RAW    = 5,
  parameter int SW     = 2
) (
  input  sb_entry_t [DEPTH:1] entries,
  input  logic                used,
  input  logic [RAW-1:0]      rs,
  output logic                hazard,
  output logic [SW-1:0]       sel
);

  logic                found;
  logic [SB_LAT_W-1:0] hit_k;
  logic [SB_LAT_W-1:0] hit_lat;

  always_comb begin
    // NOTE: every variable driven here gets a default before any branch,
    // otherwise paths that skip an assignment infer latches.
    found   = 1'b0;
    hit_k   = '0;
    hit_lat = '0;
    hazard  = 1'b0;
    sel     = '0;

    // Scan oldest to youngest so the youngest producer overwrites the rest.
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && entry_hits(entries[k], SB_REG_W'(rs))) begin
        found   = 1'b1;
        hit_k   = SB_LAT_W'(k);
        hit_lat = entries[k].lat;
      end
    end

    if (found) begin
      if (FWD_EN && (hit_k >= hit_lat)) sel = SW'(hit_k);
      else hazard = 1'b1;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage register scoreboard: tracks in-flight writes from issue to
// regfile writeback, stalls unresolved RAW hazards and picks bypass stages.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter  int NREG         = 32,
  parameter  int DEPTH        = 3,
  parameter  bit FWD_EN       = 1'b1,
  parameter  int FLUSH_STAGES = 2,
  localparam int RAW          = $clog2(NREG),
  localparam int SW           = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           issue_valid,
  input  logic [RAW-1:0] issue_rs1,
  input  logic [RAW-1:0] issue_rs2,
  input  logic           issue_use_rs1,
  input  logic           issue_use_rs2,
  input  logic           issue_we,
  input  logic [RAW-1:0] issue_rd,
  input  logic [SW-1:0]  issue_lat,
  input  logic           pipe_hold,
  input  logic           flush,
  output logic           issue_stall,
  output logic [SW-1:0]  fwd_rs1_sel,
  output logic [SW-1:0]  fwd_rs2_sel,
  output logic           busy,
  output logic [SW-1:0]  pending_cnt
);

  sb_entry_t [DEPTH:1] entries;
  sb_entry_t [DEPTH:1] entries_nxt;
  sb_entry_t           new_entry;
  logic                rs1_hazard;
  logic                rs2_hazard;
  logic                accept;
  logic [SB_LAT_W-1:0] lat_in;

  sb_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .RAW(RAW), .SW(SW)) u_match_rs1 (
    .entries (entries),
    .used    (issue_use_rs1),
    .rs      (issue_rs1),
    .hazard  (rs1_hazard),
    .sel     (fwd_rs1_sel)
  );

  sb_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .RAW(RAW), .SW(SW)) u_match_rs2 (
    .entries (entries),
    .used    (issue_use_rs2),
    .rs      (issue_rs2),
    .hazard  (rs2_hazard),
    .sel     (fwd_rs2_sel)
  );

  assign issue_stall = issue_valid & (rs1_hazard | rs2_hazard);
  assign accept      = issue_valid & ~issue_stall & ~flush & ~pipe_hold;

  // An out-of-range latency of zero is treated as a single-cycle ALU result.
  assign lat_in    = (issue_lat == '0) ? LAT_ALU : SB_LAT_W'(issue_lat);
  assign new_entry = '{valid: 1'b1, we: issue_we, rd: SB_REG_W'(issue_rd), lat: lat_in};

  // Flush kills the youngest entries in place; the shift then moves survivors.
  always_comb begin
    entries_nxt = entries;
    if (flush) begin
      for (int k = 1; k <= FLUSH_STAGES; k++) entries_nxt[k].valid = 1'b0;
    end
    if (!pipe_hold) begin
      for (int k = DEPTH; k >= 2; k--) entries_nxt[k] = entries_nxt[k-1];
      entries_nxt[1] = accept ? new_entry : '0;
    end
  end

  // NOTE: the tracker is a handful of flops, not a RAM, so it is reset
  // asynchronously so that no stale write can match straight after reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      entries <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value, independent of statement order.
      entries <= entries_nxt;
    end
  end

  always_comb begin
    busy        = 1'b0;
    pending_cnt = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      busy        = busy | entries[k].valid;
      pending_cnt = pending_cnt + SW'(entries[k].valid & entries[k].we);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios on a bypassing and a
// non-bypassing instance, then randomized traffic against an in-flight list model.
module tb_issue_scoreboard;
  import core_pkg::*;

  localparam int NREG         = 32;
  localparam int DEPTH        = 3;
  localparam int FLUSH_STAGES = 2;
  localparam int RAW          = $clog2(NREG);
  localparam int SW           = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           nrst;
  logic           iv[2], use1[2], use2[2], we[2], hold[2], fl[2];
  logic [RAW-1:0] rs1[2], rs2[2], rd[2];
  logic [SW-1:0]  lat[2];
  logic           stall[2], busy[2];
  logic [SW-1:0]  sel1[2], sel2[2], pend[2];

  int errors = 0;
  int checks = 0;

  issue_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .FWD_EN(1'b1), .FLUSH_STAGES(FLUSH_STAGES)) dut_fwd (
    .clk(clk), .nrst(nrst), .issue_valid(iv[0]), .issue_rs1(rs1[0]), .issue_rs2(rs2[0]),
    .issue_use_rs1(use1[0]), .issue_use_rs2(use2[0]), .issue_we(we[0]), .issue_rd(rd[0]),
    .issue_lat(lat[0]), .pipe_hold(hold[0]), .flush(fl[0]), .issue_stall(stall[0]),
    .fwd_rs1_sel(sel1[0]), .fwd_rs2_sel(sel2[0]), .busy(busy[0]), .pending_cnt(pend[0])
  );

  issue_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .FWD_EN(1'b0), .FLUSH_STAGES(FLUSH_STAGES)) dut_nofwd (
    .clk(clk), .nrst(nrst), .issue_valid(iv[1]), .issue_rs1(rs1[1]), .issue_rs2(rs2[1]),
    .issue_use_rs1(use1[1]), .issue_use_rs2(use2[1]), .issue_we(we[1]), .issue_rd(rd[1]),
    .issue_lat(lat[1]), .pipe_hold(hold[1]), .flush(fl[1]), .issue_stall(stall[1]),
    .fwd_rs1_sel(sel1[1]), .fwd_rs2_sel(sel2[1]), .busy(busy[1]), .pending_cnt(pend[1])
  );

  // Reference model: list of accepted instructions with their age in cycles.
  typedef struct {
    int dut;
    int rd;
    bit we;
    int lat;
    int age;
  } inflight_t;

  inflight_t mq[$];

  function automatic void model_eval(input int d, input bit fwd, input int rs, input bit used,
                                     output bit hz, output int sel);
    int best = DEPTH + 1;
    int blat = 0;
    hz  = 1'b0;
    sel = 0;
    if (!used || rs == 0) return;
    foreach (mq[i]) begin
      if (mq[i].dut == d && mq[i].we && mq[i].rd == rs && mq[i].age < best) begin
        best = mq[i].age;
        blat = mq[i].lat;
      end
    end
    if (best <= DEPTH) begin
      if (fwd && best >= blat) sel = best;
      else hz = 1'b1;
    end
  endfunction

  function automatic void model_step(input int d, input bit v, input int rdst, input bit w,
                                     input int l, input bit h, input bit f, input bit stalled);
    inflight_t keep[$];
    inflight_t e;
    foreach (mq[i]) begin
      e = mq[i];
      if (e.dut == d) begin
        if (f && e.age <= FLUSH_STAGES) continue;
        if (!h) e.age++;
        if (e.age > DEPTH) continue;
      end
      keep.push_back(e);
    end
    if (!h && !f && v && !stalled) keep.push_back('{dut: d, rd: rdst, we: w, lat: l, age: 1});
    mq = keep;
  endfunction

  function automatic int model_pending(input int d, input bit any);
    int n = 0;
    foreach (mq[i]) if (mq[i].dut == d && (any || mq[i].we)) n++;
    return n;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; use1[d] = 0; use2[d] = 0; we[d] = 0; hold[d] = 0; fl[d] = 0;
      rs1[d] = '0; rs2[d] = '0; rd[d] = '0; lat[d] = SW'(1);
    end
  endtask

  task automatic drive(input int d, input bit v, input int r1, input bit u1, input int r2,
                       input bit u2, input bit w, input int rdst, input int l, input bit h, input bit f);
    iv[d] = v; rs1[d] = RAW'(r1); use1[d] = u1; rs2[d] = RAW'(r2); use2[d] = u2;
    we[d] = w; rd[d] = RAW'(rdst); lat[d] = SW'(l); hold[d] = h; fl[d] = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    idle_all();
    mq.delete();
    #2;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    idle_all();
    drive(0, 1, 5, 1, 6, 1, 1, 5, 1, 0, 0);
    drive(1, 1, 5, 1, 6, 1, 1, 5, 1, 0, 0);
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (stall[d] !== 1'b0 || busy[d] !== 1'b0 || pend[d] !== '0 || sel1[d] !== '0 || sel2[d] !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: stall=%b busy=%b pend=%0d sel1=%0d sel2=%0d, want all 0",
                 d, stall[d], busy[d], pend[d], sel1[d], sel2[d]);
      end
    end
    idle_all();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_alu_forward();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 5, LAT_ALU, 0, 0);
    tick();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b0 || sel1[0] !== SW'(1)) begin
      errors++;
      $display("FAIL alu_forward: stall=%b sel1=%0d, want stall=0 sel1=1", stall[0], sel1[0]);
    end
    tick();
    idle_all();
    repeat (DEPTH) tick();
    checks++;
    if (busy[0] !== 1'b0 || pend[0] !== '0) begin
      errors++;
      $display("FAIL alu_drain: busy=%b pend=%0d, want 0 0", busy[0], pend[0]);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 6, LAT_LOAD, 0, 0);
    tick();
    drive(0, 1, 0, 0, 6, 1, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b, want 1", stall[0]);
    end
    tick();
    checks++;
    if (stall[0] !== 1'b0 || sel2[0] !== SW'(2) || pend[0] !== SW'(1)) begin
      errors++;
      $display("FAIL load_use_fwd: stall=%b sel2=%0d pend=%0d, want 0 2 1", stall[0], sel2[0], pend[0]);
    end
    tick();
    idle_all();
  endtask

  task automatic test_no_forward();
    apply_reset();
    drive(1, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    tick();
    drive(1, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stall[1] !== 1'b1) begin
        errors++;
        $display("FAIL nofwd_stall cycle %0d: stall=%b, want 1", i, stall[1]);
      end
      tick();
    end
    checks++;
    if (stall[1] !== 1'b0 || sel1[1] !== '0 || pend[1] !== '0) begin
      errors++;
      $display("FAIL nofwd_issue: stall=%b sel1=%0d pend=%0d, want 0 0 0", stall[1], sel1[1], pend[1]);
    end
    tick();
    idle_all();
  endtask

  task automatic test_x0_priority();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    tick();
    drive(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b0 || sel1[0] !== '0 || sel2[0] !== '0 || pend[0] !== SW'(1)) begin
      errors++;
      $display("FAIL x0_read: stall=%b sel1=%0d sel2=%0d pend=%0d, want 0 0 0 1",
               stall[0], sel1[0], sel2[0], pend[0]);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    tick();
    drive(0, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b0 || sel1[0] !== SW'(1) || pend[0] !== SW'(2)) begin
      errors++;
      $display("FAIL youngest_match: stall=%b sel1=%0d pend=%0d, want 0 1 2", stall[0], sel1[0], pend[0]);
    end
    tick();
    idle_all();
  endtask

  task automatic test_flush();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
    tick();
    drive(0, 1, 9, 1, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b0 || sel1[0] !== '0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_young: stall=%b sel1=%0d busy=%b, want 0 0 0", stall[0], sel1[0], busy[0]);
    end
    tick();
    // Flush during hold: stage DEPTH is older than the flush window and survives.
    apply_reset();
    for (int r = 11; r <= 13; r++) begin
      drive(0, 1, 0, 0, 0, 0, 1, r, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (pend[0] !== SW'(3)) begin
      errors++;
      $display("FAIL flush_pre_count: pend=%0d, want 3", pend[0]);
    end
    tick();
    drive(0, 1, 11, 1, 12, 1, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b0 || sel1[0] !== SW'(3) || sel2[0] !== '0 || pend[0] !== SW'(1) || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_hold_keep_old: stall=%b sel1=%0d sel2=%0d pend=%0d busy=%b, want 0 3 0 1 1",
               stall[0], sel1[0], sel2[0], pend[0], busy[0]);
    end
    tick();
    idle_all();
  endtask

  task automatic test_hold_reset();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 10, LAT_LOAD, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 10, 1, 0, 0, 0, 0, 1, 1, 0);
      checks++;
      if (stall[0] !== 1'b1 || pend[0] !== SW'(1)) begin
        errors++;
        $display("FAIL hold_stall cycle %0d: stall=%b pend=%0d, want 1 1", i, stall[0], pend[0]);
      end
      tick();
    end
    drive(0, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_shift: stall=%b, want 1 (producer still in stage 1)", stall[0]);
    end
    drive(0, 1, 10, 1, 0, 0, 0, 0, 1, 1, 0);
    nrst = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || stall[0] !== 1'b0 || pend[0] !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b stall=%b pend=%0d, want 0 0 0", busy[0], stall[0], pend[0]);
    end
    nrst = 1'b1;
    idle_all();
    mq.delete();
    tick();
  endtask

  task automatic test_random(input int d, input int n);
    bit v, u1, u2, w, h, f, hz1, hz2, exp_stall;
    int r1, r2, rdst, l, s1, s2;
    apply_reset();
    repeat (n) begin
      if ($urandom_range(0, 99) < 2) begin
        nrst = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (busy[d] !== 1'b0 || pend[d] !== '0) begin
          errors++;
          $display("FAIL rand_reset dut%0d: busy=%b pend=%0d, want 0 0", d, busy[d], pend[d]);
        end
        nrst = 1'b1;
      end
      v    = ($urandom_range(0, 99) < 80);
      r1   = $urandom_range(0, 3);
      r2   = $urandom_range(0, 3);
      u1   = $urandom_range(0, 1);
      u2   = $urandom_range(0, 1);
      w    = $urandom_range(0, 1);
      rdst = $urandom_range(0, 3);
      l    = $urandom_range(1, DEPTH);
      h    = ($urandom_range(0, 99) < 10);
      f    = ($urandom_range(0, 99) < 10);
      drive(d, v, r1, u1, r2, u2, w, rdst, l, h, f);
      model_eval(d, d == 0, r1, u1, hz1, s1);
      model_eval(d, d == 0, r2, u2, hz2, s2);
      exp_stall = v & (hz1 | hz2);
      checks++;
      if (stall[d] !== exp_stall) begin
        errors++;
        $display("FAIL rand_stall dut%0d t=%0t: got %b want %b", d, $time, stall[d], exp_stall);
      end
      checks++;
      if (busy[d] !== (model_pending(d, 1) != 0) || pend[d] !== SW'(model_pending(d, 0))) begin
        errors++;
        $display("FAIL rand_count dut%0d t=%0t: busy=%b pend=%0d want %0d %0d",
                 d, $time, busy[d], pend[d], model_pending(d, 1) != 0, model_pending(d, 0));
      end
      if (v && !exp_stall) begin
        checks++;
        if (sel1[d] !== SW'(s1) || sel2[d] !== SW'(s2)) begin
          errors++;
          $display("FAIL rand_sel dut%0d t=%0t: sel1=%0d sel2=%0d want %0d %0d",
                   d, $time, sel1[d], sel2[d], s1, s2);
        end
      end
      tick();
      model_step(d, v, rdst, w, l, h, f, exp_stall);
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_no_forward();
    test_x0_priority();
    test_flush();
    test_hold_reset();
    test_random(0, 600);
    test_random(1, 600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised register scoreboard and bypass selector at the issue stage of the core pipeline. It tracks every in-flight register write between issue and regfile writeback, and stalls the instruction at issue on an unresolved RAW hazard. When a hazard can be forwarded, it selects the pipeline stage to forward from. It generalises the fixed, interlock-free issue path to configurable depth, per-instruction result latency, an optional bypass network, pipeline hold and redirect flush.

## Interface
- NREG, 32, architectural register count; register 0 is hard-wired zero
- DEPTH, 3, stages between issue and regfile write (stage 1 = issued last cycle; stage DEPTH writes regfile at end of its cycle)
- FWD_EN, 1, 1 = bypass network present; 0 = every hazard stalls until writeback
- FLUSH_STAGES, 2, youngest stages invalidated by a redirect (1..DEPTH)
- Derived: RAW = $clog2(NREG), SW = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- issue_valid  in  1  instruction present at issue
- issue_rs1, issue_rs2  in  RAW  source registers
- issue_use_rs1, issue_use_rs2  in  1  source actually read
- issue_we  in  1  instruction writes rd
- issue_rd  in  RAW  destination
- issue_lat  in  SW  cycles until result forwardable, 1..DEPTH (ALU 1, load 2)
- pipe_hold  in  1  whole pipeline frozen this cycle
- flush  in  1  branch/jump redirect from execute
- issue_stall  out  1  hold instruction at issue, insert bubble
- fwd_rs1_sel, fwd_rs2_sel  out  SW  0 = regfile, k = forward from stage k
- busy  out  1  any valid tracked entry
- pending_cnt  out  SW  number of valid entries with we=1

## Operation
- Tracker: DEPTH entries {valid, we, rd, lat}. Each non-held cycle, entry k moves to k+1. Entry DEPTH retires. Stage 1 loads the issued instruction, or a bubble (valid=0) when stalled, flushed or issue_valid=0.
- Match for an operand: use=1, rs≠0, and entry valid, we=1, rd==rs. Only the youngest match (smallest k) counts.
- Youngest match at k with FWD_EN=1: k ≥ lat gives sel=k with no stall; k < lat stalls.
- Youngest match with FWD_EN=0: always stalls, sel=0.
- No match: sel=0.
- issue_stall = issue_valid & (rs1 hazard | rs2 hazard). sel is meaningful only when issue_valid & !issue_stall.
- Flush: entries 1..FLUSH_STAGES become invalid. The issue instruction is not accepted, so stage 1 loads a bubble. Older entries advance normally.
- pipe_hold: no shift and no accept. Outputs are still evaluated against the frozen state. If hold and flush coincide, flush invalidation applies without a shift.
- Writes to rd=0 are tracked but never match.

## Timing
- issue_stall, fwd_*_sel: combinational from registered tracker state and the current issue_* inputs, same cycle.
- busy, pending_cnt: combinational from tracker state.
- Tracker updates on posedge clk.
- Accepted instruction appears in stage 1 the next cycle. Its regfile write happens DEPTH cycles after issue.
- Reset (nrst low, any time including mid-stream): all entries invalid immediately. issue_stall=0 (with no match), fwd sels=0, busy=0, pending_cnt=0.
- First accept is on the first posedge after nrst rises.
- Max stall for one operand: DEPTH cycles with FWD_EN=0; lat−1 cycles with FWD_EN=1.

## Structure
- core_pkg: typedef sb_entry_t {valid, we, rd, lat}; localparams for ALU/load latency codes (LAT_ALU=1, LAT_LOAD=2).
- Sub-module sb_match: per-operand youngest-match priority encoder plus stall/sel decision, instanced twice (rs1, rs2) inside issue_scoreboard.

## Test plan
- DEPTH=3, FWD_EN=1. Issue write x5 lat1; next cycle issue read rs1=x5 → issue_stall=0, fwd_rs1_sel=1.
- Load-use. Issue x6 lat2; next cycle read rs2=x6 → stall for 1 cycle, then stall=0 and fwd_rs2_sel=2. The stall cycle leaves a bubble in stage 1 (pending_cnt stays 1).
- FWD_EN=0. Write x7; dependent read → stall for 3 cycles, issues on the 4th cycle with sel=0. pending_cnt returns to 0 after retire.
- x0 and priority. Issue write x0 lat3; read x0 → no stall, sel=0. Then issue x8 lat1 twice back-to-back and read x8 → fwd_rs1_sel=1 (youngest), not 2.
- Flush. Issue x9 lat3; next cycle assert flush with a dependent at issue → dependent not accepted. The cycle after, the dependent re-presented → no stall, sel=0, busy=0.
- Hold and reset. Issue x10 lat2, assert pipe_hold 3 cycles with dependent → stall held throughout, with no shift. Then drop nrst mid-hold → busy=0, stall=0 asynchronously.
